rete_combinatoria_lut: RTL and testbench
========================================

// Module: rete_combinatoria_lut
// PURPOSE
//  Programmable, registered successor of the fixed 4-input SdP networks: an N_IN-input,
//  N_OUT-output truth table held in flops, evaluated through a valid/ready pipeline stage.
//  Table is rewritable at run time (single-entry write, or bulk clear by FSM sweep).
//  Sits between an operand producer and consumer in chapter-II style datapath exercises.
// PARAMETERS
//  N_IN          4         number of input variables x; table depth = 2**N_IN (1..8)
//  N_OUT         1         output variables per minterm (table word width, 1..8)
//  RESET_TABLE   16'hA7F7  reset content, flattened {entry[2**N_IN-1],...,entry[0]};
//                          default = z=0 on x?011 and x11?0, 1 elsewhere
// PORTS
//  clock        in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high
//  prog_we      in   1      write table entry prog_addr with prog_data
//  prog_addr    in   N_IN   minterm index {x[N_IN-1],...,x[0]}
//  prog_data    in   N_OUT  new output word for that minterm
//  prog_clr     in   1      start bulk clear (all entries to 0)
//  busy         out  1      clear sweep in progress
//  in_valid     in   1      x is valid
//  in_ready     out  1      block accepts x this cycle
//  x            in   N_IN   input variables
//  out_valid    out  1      z is valid
//  out_ready    in   1      consumer takes z this cycle
//  z            out  N_OUT  table[x] for the accepted x
//  ones_count   out  16     (RC_STATS_EN only) see CONFIGURATION
// BEHAVIOUR
//  Reset: table=RESET_TABLE, state=RUN, busy=0, out_valid=0, z=0, clr_ptr=0, ones_count=0.
//  FSM RUN:   in_ready = !out_valid | out_ready. prog_clr=1 -> CLEAR, clr_ptr=0 next cycle.
//  FSM CLEAR: busy=1, in_ready=0; writes 0 to entry clr_ptr each cycle, clr_ptr++;
//             after entry 2**N_IN-1 written -> RUN (sweep = 2**N_IN cycles).
//             prog_we and prog_clr ignored in CLEAR; out_valid/z hold until drained by out_ready.
//  Accept = in_valid & in_ready: next cycle out_valid=1, z=table[x] (latency 1).
//  out_valid & out_ready & !accept -> out_valid=0; z holds its last value.
//  Back-to-back accepts every cycle while out_ready=1 (full throughput).
//  Write (RUN only): entry updated at the clock edge; visible to accepts from next cycle.
//  Same-cycle accept and write at the same address: z gets OLD content (read-before-write).
//  prog_we & prog_clr same cycle in RUN: clear wins, write dropped.
//  x, prog_addr use all N_IN bits; no out-of-range index exists.
//  Reset mid-CLEAR or mid-transfer: table returns to RESET_TABLE, out_valid drops immediately.
// CONFIGURATION
//  RC_STATS_EN defined: ones_count port present; +1 per accept whose looked-up z[0]=1,
//   saturates at 16'hFFFF, cleared by reset and by entry into CLEAR.
//  RC_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package rete_lut_pkg: state enum {RUN, CLEAR}; default RESET_TABLE constant;
//   localparam DEPTH = 2**N_IN helper.
//  Sub-module lut_mem: DEPTH x N_OUT flop array, async-reset to RESET_TABLE,
//   one write port, one combinational read port. Top holds FSM, pipeline reg, counter.
// TESTING
//  1 After reset, drive x=0..15 with out_ready=1 -> z = 1,1,1,0,1,1,1,1,1,1,1,0,0,1,0,1.
//  2 prog_we addr=3 data=1, then x=3 -> z=1; same-cycle write addr=11 data=1 with accept
//    x=11 -> z=0, next accept x=11 -> z=1.
//  3 out_ready=0 with out_valid=1: in_ready=0, z stable; release -> queued x delivered, no loss.
//  4 prog_clr: busy=1 exactly 16 cycles, in_ready=0, prog_we ignored; afterwards every x -> z=0.
//  5 Assert reset during CLEAR at clr_ptr=7: busy=0, out_valid=0, table back to 16'hA7F7.
//  6 RC_STATS_EN: 16 accepts x=0..15 -> ones_count=12; prog_clr -> 0; force 65540 ones -> 16'hFFFF.

Source files
------------

// File: rtl/rete_lut_pkg.sv
// Shared types and constants for the programmable truth-table network.
// The RC_STATS_EN build macro is honoured by rete_combinatoria_lut, not here.
package rete_lut_pkg;

    typedef enum logic {
        RUN,
        CLEAR
    } state_e;

    // z=0 on x?011 and x11?0, 1 elsewhere
    localparam logic [15:0] RC_RESET_TABLE = 16'hA7F7;

    function automatic int lutDepth(input int nIn);
        return 2 ** nIn;
    endfunction

endpackage

// File: rtl/lut_mem.sv
// Flop-based truth table: DEPTH x N_OUT words, async reset to a preset image,
// one synchronous write port and one combinational read port.
module lut_mem
    import rete_lut_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [lutDepth(N_IN)*N_OUT-1:0] RESET_TABLE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_i,
    input  logic [N_IN-1:0]  waddr_i,
    input  logic [N_OUT-1:0] wdata_i,
    input  logic [N_IN-1:0]  raddr_i,
    output logic [N_OUT-1:0] rdata_o
);

    localparam int DEPTH = lutDepth(N_IN);

    logic [N_OUT-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_TABLE[i*N_OUT +: N_OUT];
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rete_combinatoria_lut.sv
// Programmable registered truth-table stage with valid/ready handshake and bulk clear.
// Optional build macro RC_STATS_EN adds the ones_count port and its counter.
module rete_combinatoria_lut
    import rete_lut_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [lutDepth(N_IN)*N_OUT-1:0] RESET_TABLE =
        (lutDepth(N_IN)*N_OUT)'(RC_RESET_TABLE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             prog_we,
    input  logic [N_IN-1:0]  prog_addr,
    input  logic [N_OUT-1:0] prog_data,
    input  logic             prog_clr,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] z
`ifdef RC_STATS_EN
    ,
    output logic [15:0]      ones_count
`endif
);

    localparam int DEPTH = lutDepth(N_IN);
    localparam logic [N_IN-1:0] LAST_ENTRY = N_IN'(DEPTH - 1);

    state_e           state_q;
    logic [N_IN-1:0]  clrPtr_q;
    logic             busy_q;
    logic             outValid_q, outValid_d;
    logic [N_OUT-1:0] z_q, z_d;

    logic             inReady;
    logic             accept;
    logic             startClear;
    logic             memWe;
    logic [N_IN-1:0]  memWaddr;
    logic [N_OUT-1:0] memWdata;
    logic [N_OUT-1:0] memRdata;

    assign inReady    = (state_q == RUN) && (!outValid_q || out_ready);
    assign accept     = in_valid && inReady;
    assign startClear = (state_q == RUN) && prog_clr;

    // The sweep owns the write port while clearing; in RUN a clear request drops a same-cycle write.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = prog_addr;
        memWdata = prog_data;
        if (state_q == CLEAR) begin
            memWe    = 1'b1;
            memWaddr = clrPtr_q;
            memWdata = '0;
        end else if (prog_we && !prog_clr) begin
            memWe    = 1'b1;
        end
    end

    lut_mem #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .RESET_TABLE(RESET_TABLE)
    ) u_lut_mem (
        .clock  (clock),
        .reset  (reset),
        .we_i   (memWe),
        .waddr_i(memWaddr),
        .wdata_i(memWdata),
        .raddr_i(x),
        .rdata_o(memRdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            clrPtr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (prog_clr) begin
                        state_q  <= CLEAR;
                        clrPtr_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    clrPtr_q <= clrPtr_q + 1'b1;
                    if (clrPtr_q == LAST_ENTRY) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register keeps z after a transfer so the consumer sees a stable last value.
    always_comb begin
        outValid_d = outValid_q;
        z_d        = z_q;
        if (accept) begin
            outValid_d = 1'b1;
            z_d        = memRdata;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid_q <= 1'b0;
            z_q        <= '0;
        end else begin
            outValid_q <= outValid_d;
            z_q        <= z_d;
        end
    end

`ifdef RC_STATS_EN
    logic [15:0] onesCount_q, onesCount_d;

    always_comb begin
        onesCount_d = onesCount_q;
        if (startClear) begin
            onesCount_d = '0;
        end else if (accept && memRdata[0] && (onesCount_q != 16'hFFFF)) begin
            onesCount_d = onesCount_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            onesCount_q <= '0;
        end else begin
            onesCount_q <= onesCount_d;
        end
    end

    assign ones_count = onesCount_q;
`else
    logic unusedStartClear;
    assign unusedStartClear = startClear;
`endif

    assign busy      = busy_q;
    assign in_ready  = inReady;
    assign out_valid = outValid_q;
    assign z         = z_q;

endmodule

// File: tb/tb_rete_combinatoria_lut.sv
// Scoreboard bench for rete_combinatoria_lut: a truth-table reference model pushes
// expected z on every accept, and an independent monitor pops on each transfer.
module tb_rete_combinatoria_lut;

    logic       clock;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [0:0] prog_data;
    logic       prog_clr;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] z;
`ifdef RC_STATS_EN
    logic [15:0] ones_count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    bit  mTable [16];
    int  mClear;
    bit  mOutValid;
    int  mOnes;
    bit  scoreQ [$];

    rete_combinatoria_lut dut (
        .clock     (clock),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_clr  (prog_clr),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef RC_STATS_EN
        .ones_count(ones_count),
`endif
        .z         (z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; they change 2 time units after the rising edge.
    task automatic applyStimulus(input bit v, input logic [3:0] xv, input bit rdy,
                                 input bit we, input logic [3:0] a, input bit d, input bit clr);
        in_valid  = v;
        x         = xv;
        out_ready = rdy;
        prog_we   = we;
        prog_addr = a;
        prog_data = d;
        prog_clr  = clr;
        @(posedge clock);
        #2;
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        prog_we  = 1'b0;
        prog_clr = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && scoreQ.size() != 0; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("drain_queue_empty", 32'(scoreQ.size()), 32'd0);
    endtask

    task automatic sweepAll();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        drain();
    endtask

    // Reference model: plain table plus handshake bookkeeping, evaluated mid-cycle.
    always @(negedge clock) begin
        bit [15:0] img;
        bit        expReady;
        bit        acc;
        if (reset) begin
            img = 16'hA7F7;
            for (int i = 0; i < 16; i++) mTable[i] = img[i];
            mClear    = 0;
            mOutValid = 1'b0;
            mOnes     = 0;
            scoreQ.delete();
        end else begin
            expReady = (mClear == 0) && (!mOutValid || out_ready);
            checkOutput("in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("busy", 32'(busy), 32'(mClear != 0));
            checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
`ifdef RC_STATS_EN
            checkOutput("ones_count", 32'(ones_count), 32'(mOnes));
`endif
            acc = in_valid && expReady;
            if (acc) begin
                scoreQ.push_back(mTable[x]);
                if (mTable[x] && mOnes < 65535) mOnes++;
            end
            if (mClear > 0) begin
                mClear--;
            end else if (prog_clr) begin
                mClear = 16;
                for (int i = 0; i < 16; i++) mTable[i] = 1'b0;
                mOnes = 0;
            end else if (prog_we) begin
                mTable[prog_addr] = prog_data[0];
            end
            mOutValid = acc ? 1'b1 : (out_ready ? 1'b0 : mOutValid);
        end
    end

    // Monitor: z must match the oldest outstanding expectation whenever it is presented.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (scoreQ.size() == 0) begin
                checkOutput("z_unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                checkOutput("z", 32'(z), 32'(scoreQ[0]));
                if (out_ready) void'(scoreQ.pop_front());
            end
        end
    end

    initial begin
        int busyCycles;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_clr  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        doReset();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_z", 32'(z), 32'd0);

        $display("[TB] reset-table sweep");
        sweepAll();
`ifdef RC_STATS_EN
        checkOutput("ones_after_sweep", 32'(ones_count), 32'd12);
`endif

        $display("[TB] programming and read-before-write");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd11, 1'b1, 1'b1, 4'd11, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drain();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            applyStimulus(1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drain();

        $display("[TB] bulk clear");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        busyCycles = 0;
        while (busy && busyCycles < 40) begin
            busyCycles++;
            checkOutput("clear_in_ready", 32'(in_ready), 32'd0);
            applyStimulus(1'b1, 4'(busyCycles), 1'b1, 1'b1, 4'(busyCycles), 1'b1, 1'b1);
        end
        checkOutput("clear_busy_cycles", 32'(busyCycles), 32'd16);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        sweepAll();

        $display("[TB] reset during clear");
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        checkOutput("midclear_busy", 32'(busy), 32'd1);
        checkOutput("midclear_out_valid", 32'(out_valid), 32'd1);
        doReset();
        out_ready = 1'b1;
        sweepAll();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 40 && busy; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        drain();
        sweepAll();

`ifdef RC_STATS_EN
        $display("[TB] ones_count saturation");
        doReset();
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        drain();
        checkOutput("ones_saturated", 32'(ones_count), 32'h0000FFFF);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("ones_after_clear", 32'(ones_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
